// File: rtl/pkt_ser_pkg.sv
// rtl/pkt_ser_pkg.sv - shared state encoding, framing defaults and frame-length helper
package pkt_ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_FTR  = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    localparam logic [7:0] HDR_PAT_DEF = 8'hA5;
    localparam logic [7:0] FTR_PAT_DEF = 8'h5A;

    // Cycles with frm_o high for one packet of len+1 data bits.
    function automatic int frame_len(input int hw, input int lw, input int len);
        return 2 * hw + lw + len + 1;
    endfunction

endpackage

// File: rtl/pkt_ser.sv
// rtl/pkt_ser.sv - framed serial packetizer: header, length, data, footer, idle gap
module pkt_ser
    import pkt_ser_pkg::*;
#(
    parameter int             DW        = 32,
    parameter int             LW        = $clog2(DW),
    parameter int             HW        = 8,
    parameter logic [HW-1:0]  HDR_PAT   = HDR_PAT_DEF,
    parameter logic [HW-1:0]  FTR_PAT   = FTR_PAT_DEF,
    parameter bit             MSB_FIRST = 1'b1,
    parameter int             GAP       = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic [LW-1:0] len_i,
    input  logic          vld_i,
    output logic          ack_o,
    output logic          dat_o,
    output logic          frm_o,
    output logic          busy_o
);

    // Counter also has to hold GAP-1, so it is widened if GAP is unusually large.
    localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int CW0 = (HW > DW) ? HW : DW;
    localparam int CW  = (GW > CW0) ? GW : CW0;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [DW-1:0] dat_q;
    logic [LW-1:0] len_q;
    logic          cap;
    logic          ack_n, bit_n, frm_n, busy_n;
    logic [CW-1:0] didx;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ack_n   = 1'b0;
        cap     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (vld_i) begin
                state_n = ST_HDR;
                cnt_n   = CW'(HW - 1);
                ack_n   = 1'b1;
                cap     = 1'b1;
            end
        end else if (cnt_q != '0) begin
            cnt_n = cnt_q - CW'(1);
        end else begin
            case (state_q)
                ST_HDR: begin
                    state_n = ST_LEN;
                    cnt_n   = CW'(LW - 1);
                end
                ST_LEN: begin
                    state_n = ST_DATA;
                    cnt_n   = CW'(len_q);
                end
                ST_DATA: begin
                    state_n = ST_FTR;
                    cnt_n   = CW'(HW - 1);
                end
                ST_FTR: begin
                    if (GAP == 0) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_GAP;
                        cnt_n   = CW'(GAP - 1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        bit_n  = 1'b0;
        didx   = MSB_FIRST ? cnt_n : (CW'(len_q) - cnt_n);
        frm_n  = (state_n == ST_HDR) || (state_n == ST_LEN) ||
                 (state_n == ST_DATA) || (state_n == ST_FTR);
        busy_n = (state_n != ST_IDLE);
        case (state_n)
            ST_HDR: begin
                for (int i = 0; i < HW; i++)
                    if (cnt_n == CW'(i)) bit_n = HDR_PAT[i];
            end
            ST_LEN: begin
                for (int i = 0; i < LW; i++)
                    if (cnt_n == CW'(i)) bit_n = len_q[i];
            end
            ST_DATA: begin
                for (int i = 0; i < DW; i++)
                    if (didx == CW'(i)) bit_n = dat_q[i];
            end
            ST_FTR: begin
                for (int i = 0; i < HW; i++)
                    if (cnt_n == CW'(i)) bit_n = FTR_PAT[i];
            end
            default: bit_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dat_q   <= '0;
            len_q   <= '0;
            ack_o   <= 1'b0;
            dat_o   <= 1'b0;
            frm_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            if (cap) begin
                dat_q <= dat_i;
                len_q <= len_i;
            end
            ack_o   <= ack_n;
            dat_o   <= bit_n;
            frm_o   <= frm_n;
            busy_o  <= busy_n;
        end
    end

endmodule

// File: tb/tb_pkt_ser.sv
// tb/tb_pkt_ser.sv - directed self-checking bench for pkt_ser (32-bit MSB-first and 8-bit LSB-first)
module tb_pkt_ser;

    localparam int GAP_TB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] dat32;
    logic [4:0]  len32;
    logic        vld32, ack32, dato32, frm32, busy32;
    logic [7:0]  dat8;
    logic [2:0]  len8;
    logic        vld8, ack8, dato8, frm8, busy8;

    pkt_ser #(.DW(32), .MSB_FIRST(1'b1), .GAP(GAP_TB)) u32 (
        .clk_i(clk), .rst_i(rst), .dat_i(dat32), .len_i(len32), .vld_i(vld32),
        .ack_o(ack32), .dat_o(dato32), .frm_o(frm32), .busy_o(busy32)
    );

    pkt_ser #(.DW(8), .MSB_FIRST(1'b0), .GAP(GAP_TB)) u8 (
        .clk_i(clk), .rst_i(rst), .dat_i(dat8), .len_i(len8), .vld_i(vld8),
        .ack_o(ack8), .dat_o(dato8), .frm_o(frm8), .busy_o(busy8)
    );

    typedef struct {
        int          sel;
        logic [31:0] dat;
        int          len;
        int          exp_f;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] d, input int l);
        if (sel == 0) begin
            vld32 = v; dat32 = d; len32 = 5'(l);
        end else begin
            vld8 = v; dat8 = d[7:0]; len8 = 3'(l);
        end
    endtask

    task automatic sample(input int sel, output logic a, output logic dd, output logic f, output logic b);
        if (sel == 0) begin
            a = ack32; dd = dato32; f = frm32; b = busy32;
        end else begin
            a = ack8; dd = dato8; f = frm8; b = busy8;
        end
    endtask

    task automatic send_and_check(input int sel, input logic [31:0] d, input int l, input int f);
        bit          exp_q[$];
        logic [7:0]  hp, fp;
        logic [31:0] lv;
        logic        a, dd, fr, b;
        int          lw;
        hp = 8'hA5;
        fp = 8'h5A;
        lv = 32'(l);
        lw = (sel == 0) ? 5 : 3;
        for (int i = 7; i >= 0; i--) exp_q.push_back(hp[i]);
        for (int i = lw - 1; i >= 0; i--) exp_q.push_back(lv[i]);
        if (sel == 0) begin
            for (int i = l; i >= 0; i--) exp_q.push_back(d[i]);
        end else begin
            for (int i = 0; i <= l; i++) exp_q.push_back(d[i]);
        end
        for (int i = 7; i >= 0; i--) exp_q.push_back(fp[i]);

        drive(sel, 1'b1, d, l);
        tick;
        drive(sel, 1'b0, 32'h0, 0);
        for (int k = 1; k <= f + GAP_TB + 1; k++) begin
            sample(sel, a, dd, fr, b);
            check($sformatf("ack s%0d d%0h c%0d", sel, d, k), 32'(a), 32'(k == 1));
            check($sformatf("frm s%0d d%0h c%0d", sel, d, k), 32'(fr), 32'(k <= f));
            check($sformatf("busy s%0d d%0h c%0d", sel, d, k), 32'(b), 32'(k <= f + GAP_TB));
            check($sformatf("dat s%0d d%0h c%0d", sel, d, k), 32'(dd),
                  32'((k <= f && k - 1 < exp_q.size()) ? exp_q[k - 1] : 1'b0));
            tick;
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   acks, last, frms;

        vecs[0] = '{0, 32'hDEADBEEF, 31, 53};
        vecs[1] = '{0, 32'h00000001, 0,  22};
        vecs[2] = '{0, 32'hFFFF1234, 15, 37};
        vecs[3] = '{1, 32'h00000001, 7,  27};
        vecs[4] = '{1, 32'h000000C4, 2,  22};
        vecs[5] = '{0, 32'h0000005A, 7,  29};

        // Reset held with valid asserted: nothing may start.
        rst = 1'b1;
        drive(0, 1'b1, 32'hCAFEF00D, 31);
        drive(1, 1'b1, 32'h000000FF, 7);
        for (int c = 0; c < 3; c++) begin
            tick;
            check($sformatf("rst ack32 c%0d", c),  32'(ack32),  32'h0);
            check($sformatf("rst dat32 c%0d", c),  32'(dato32), 32'h0);
            check($sformatf("rst frm32 c%0d", c),  32'(frm32),  32'h0);
            check($sformatf("rst busy32 c%0d", c), 32'(busy32), 32'h0);
            check($sformatf("rst ack8 c%0d", c),   32'(ack8),   32'h0);
            check($sformatf("rst frm8 c%0d", c),   32'(frm8),   32'h0);
            check($sformatf("rst busy8 c%0d", c),  32'(busy8),  32'h0);
        end
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 0);
        drive(1, 1'b0, 32'h0, 0);
        tick;
        check("post-rst busy32", 32'(busy32), 32'h0);
        check("post-rst ack32",  32'(ack32),  32'h0);

        for (int v = 0; v < 6; v++)
            send_and_check(vecs[v].sel, vecs[v].dat, vecs[v].len, vecs[v].exp_f);

        // Valid held high on the 8-bit instance: captures 27+2+1 cycles apart.
        acks = 0;
        last = -1;
        frms = 0;
        drive(1, 1'b1, 32'h3C, 7);
        for (int c = 0; c < 120; c++) begin
            tick;
            if (frm8) frms++;
            if (ack8) begin
                acks++;
                if (last >= 0) check($sformatf("b2b spacing ack%0d", acks), 32'(c - last), 32'd30);
                last = c;
                if (acks < 3) dat8 = 8'(8'h3C + acks);
                else vld8 = 1'b0;
            end
        end
        check("b2b ack count", 32'(acks), 32'd3);
        check("b2b frame cycles", 32'(frms), 32'd81);
        check("b2b idle busy", 32'(busy8), 32'h0);

        // Reset on the 5th data bit of a full word truncates the frame.
        drive(0, 1'b1, 32'h12345678, 31);
        tick;
        drive(0, 1'b0, 32'h0, 0);
        for (int c = 0; c < 17; c++) tick;
        check("mid frm before rst", 32'(frm32),  32'h1);
        check("mid 5th data bit",   32'(dato32), 32'h0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid-rst frm",  32'(frm32),  32'h0);
        check("mid-rst dat",  32'(dato32), 32'h0);
        check("mid-rst busy", 32'(busy32), 32'h0);
        check("mid-rst ack",  32'(ack32),  32'h0);
        tick;
        check("mid-rst idle busy", 32'(busy32), 32'h0);
        check("mid-rst idle ack",  32'(ack32),  32'h0);
        send_and_check(0, 32'h0000000A, 3, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
